// File: rtl/dm_controller.sv
// Data-memory subsystem: the host preloads operands, the processor runs against the memory,
// then the host drains a result region. A sequencer decides who owns the memory each cycle.
module dm_controller #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [16:0]       proc_wdata,
  input  logic              proc_we,
  input  logic              end_process,
  output logic [DATA_W-1:0] dm_out,
  output logic              proc_start,
  output logic              run_active,
  input  logic              load_go,
  input  logic [ADDR_W:0]   load_len,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W:0]   dump_len,
  input  logic              host_wvalid,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_wready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_rready,
  output logic              done,
  output logic [2:0]        dbg_state
);

  // Valid/ready: a word moves on a rising edge where valid and ready are both high; once
  // valid is raised it stays high with stable data until that edge.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_DUMP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W:0]   load_len_q;
  logic [ADDR_W:0]   dump_len_q;
  logic [ADDR_W-1:0] dump_base_q;
  logic [ADDR_W-1:0] dump_addr;
  logic              start_q;
  logic              load_fire;
  logic              dump_fire;
  logic              last_load;
  logic              last_dump;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              unused_wdata_hi;

  assign unused_wdata_hi = ^proc_wdata[16:DATA_W];

  assign cnt_inc   = cnt + (ADDR_W+1)'(1);
  // Adding in ADDR_W bits makes the result region wrap from DEPTH-1 back to 0.
  assign dump_addr = dump_base_q + cnt[ADDR_W-1:0];
  assign load_fire = (state == S_LOAD) && host_wvalid;
  assign dump_fire = (state == S_DUMP) && host_rvalid && host_rready;
  assign last_load = (cnt_inc == load_len_q);
  assign last_dump = (cnt_inc == dump_len_q);

  assign host_wready = (state == S_LOAD);
  assign run_active  = (state == S_RUN);
  assign done        = (state == S_DONE);
  assign proc_start  = start_q;
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (load_go) state_nxt = (load_len == '0) ? S_RUN : S_LOAD;
      S_LOAD:         if (load_fire && last_load) state_nxt = S_RUN;
      S_RUN:          if (end_process) state_nxt = (dump_len_q == '0) ? S_DONE : S_DUMP;
      S_DUMP:         if (dump_fire && last_dump) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Single write port: the host owns it during LOAD, the processor during RUN.
  always_comb begin
    mem_we    = load_fire || ((state == S_RUN) && proc_we);
    mem_waddr = proc_addr;
    mem_wdata = proc_wdata[DATA_W-1:0];
    if (state == S_LOAD) begin
      mem_waddr = cnt[ADDR_W-1:0];
      mem_wdata = host_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      load_len_q  <= '0;
      dump_len_q  <= '0;
      dump_base_q <= '0;
      start_q     <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      dm_out      <= '0;
    end else begin
      start_q <= (state_nxt == S_RUN) && (state != S_RUN);
      unique case (state)
        S_IDLE, S_DONE: begin
          if (load_go) begin
            load_len_q  <= load_len;
            dump_len_q  <= dump_len;
            dump_base_q <= dump_base;
            cnt         <= '0;
          end
        end
        S_LOAD: begin
          if (load_fire) cnt <= cnt_inc;
        end
        S_RUN: begin
          // Nonblocking read beside the write port gives read-before-write on a collision.
          dm_out <= mem[proc_addr];
          if (end_process) cnt <= '0;
        end
        S_DUMP: begin
          if (!host_rvalid) begin
            host_rdata  <= mem[dump_addr];
            host_rvalid <= 1'b1;
          end else if (host_rready) begin
            host_rvalid <= 1'b0;
            cnt         <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_controller.sv
// Scenario-per-task bench for dm_controller with a word-array memory model kept in the bench.
module tb_dm_controller;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] proc_addr = '0;
  logic [16:0]       proc_wdata = '0;
  logic              proc_we = 1'b0;
  logic              end_process = 1'b0;
  logic [DATA_W-1:0] dm_out;
  logic              proc_start;
  logic              run_active;
  logic              load_go = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic [ADDR_W-1:0] dump_base = '0;
  logic [ADDR_W:0]   dump_len = '0;
  logic              host_wvalid = 1'b0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_wready;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rready = 1'b0;
  logic              done;
  logic [2:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem_m [DEPTH];
  bit                known [DEPTH];
  logic [DATA_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  dm_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_we(proc_we),
    .end_process(end_process), .dm_out(dm_out), .proc_start(proc_start),
    .run_active(run_active), .load_go(load_go), .load_len(load_len),
    .dump_base(dump_base), .dump_len(dump_len), .host_wvalid(host_wvalid),
    .host_wdata(host_wdata), .host_wready(host_wready), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .host_rready(host_rready), .done(done),
    .dbg_state(dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({dm_out, proc_start, run_active, host_wready, host_rvalid, host_rdata, done} !== '0) begin
      errors++;
      $display("FAIL %s: dm_out=%h start=%b run=%b wready=%b rvalid=%b rdata=%h done=%b, required all zero",
               name, dm_out, proc_start, run_active, host_wready, host_rvalid, host_rdata, done);
    end
  endtask

  task automatic start_session(input int ll, input int base, input int dl);
    load_len  = (ADDR_W+1)'(ll);
    dump_base = ADDR_W'(base);
    dump_len  = (ADDR_W+1)'(dl);
    load_go   = 1'b1;
    tick();
    load_go = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL session_done_clear: got %b required 0", done);
    end
    checks++;
    if (ll == 0) begin
      if ({run_active, proc_start, host_wready} !== 3'b110) begin
        errors++;
        $display("FAIL session_direct_run: run/start/wready=%b required 110",
                 {run_active, proc_start, host_wready});
      end
    end else if ({run_active, host_wready} !== 2'b01) begin
      errors++;
      $display("FAIL session_enter_load: run/wready=%b required 01", {run_active, host_wready});
    end
  endtask

  // Presents exp_q as preload words, with a colliding processor write that must be ignored.
  task automatic load_words();
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      host_wvalid = 1'b1;
      host_wdata  = exp_q[i];
      proc_we     = 1'b1;
      proc_addr   = ADDR_W'(i);
      proc_wdata  = 17'($urandom());
      checks++;
      if (host_wready !== 1'b1) begin
        errors++;
        $display("FAIL load_wready word %0d: got %b required 1", i, host_wready);
      end
      tick();
      mem_m[i] = exp_q[i];
      known[i] = 1'b1;
    end
    host_wvalid = 1'b0;
    proc_we     = 1'b0;
    checks++;
    if ({host_wready, run_active, proc_start} !== 3'b011) begin
      errors++;
      $display("FAIL load_to_run: wready/run/start=%b required 011",
               {host_wready, run_active, proc_start});
    end
    exp_q.delete();
  endtask

  task automatic proc_op(input int a, input bit we, input logic [16:0] wd);
    logic [DATA_W-1:0] expv;
    bit                chk;
    proc_addr  = ADDR_W'(a);
    proc_we    = we;
    proc_wdata = wd;
    chk  = known[a];
    expv = mem_m[a];
    tick();
    proc_we = 1'b0;
    if (we) begin
      mem_m[a] = wd[DATA_W-1:0];
      known[a] = 1'b1;
    end
    checks++;
    if (!run_active || proc_start || (chk && dm_out !== expv)) begin
      errors++;
      $display("FAIL proc_read addr %h: dm_out=%h required %h (run=%b start=%b)",
               a, dm_out, expv, run_active, proc_start);
    end
  endtask

  task automatic run_ops(input int n, input int lo, input int hi);
    for (int i = 0; i < n; i++)
      proc_op($urandom_range(lo, hi), 1'($urandom_range(0, 1)), 17'($urandom()));
  endtask

  task automatic end_run(input bit we, input int a, input logic [16:0] wd);
    end_process = 1'b1;
    proc_we     = we;
    proc_addr   = ADDR_W'(a);
    proc_wdata  = wd;
    tick();
    end_process = 1'b0;
    proc_we     = 1'b0;
    if (we) begin
      mem_m[a] = wd[DATA_W-1:0];
      known[a] = 1'b1;
    end
    checks++;
    if (run_active !== 1'b0) begin
      errors++;
      $display("FAIL end_run: run_active=%b required 0", run_active);
    end
  endtask

  task automatic dump_and_check(input int base, input int len, input int stall_word, input int stall_n);
    int waited;
    int a;
    int k;
    logic [DATA_W-1:0] expv;
    host_rready = 1'b0;
    for (int i = 0; i < len; i++) begin
      a = (base + i) % DEPTH;
      expv = mem_m[a];
      waited = 0;
      while (!host_rvalid && waited < 20) begin
        tick();
        waited++;
      end
      checks++;
      if (!host_rvalid || waited != 1) begin
        errors++;
        $display("FAIL dump_latency word %0d: rvalid=%b after %0d cycles, required 1 after 1",
                 i, host_rvalid, waited);
        return;
      end
      checks++;
      if (host_rdata !== expv) begin
        errors++;
        $display("FAIL dump_data word %0d addr %h: got %h required %h", i, a, host_rdata, expv);
      end
      k = (i == stall_word) ? stall_n : $urandom_range(0, 2);
      for (int s = 0; s < k; s++) begin
        tick();
        checks++;
        if (host_rvalid !== 1'b1 || host_rdata !== expv) begin
          errors++;
          $display("FAIL dump_stall word %0d: rvalid=%b rdata=%h required 1 %h",
                   i, host_rvalid, host_rdata, expv);
        end
      end
      host_rready = 1'b1;
      tick();
      host_rready = 1'b0;
      checks++;
      if (host_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL dump_handshake word %0d: rvalid=%b required 0", i, host_rvalid);
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL dump_done: done=%b required 1", done);
    end
  endtask

  task automatic test_reset();
    #2;
    check_all_zero("reset_async");
    tick();
    rst_n = 1'b1;
    tick();
    check_all_zero("reset_idle");
  endtask

  task automatic test_load_run_dump();
    start_session(3, 1, 2);
    exp_q.push_back(12'h0A1);
    exp_q.push_back(12'h0B2);
    exp_q.push_back(12'h0C3);
    load_words();
    proc_op(1, 1'b0, 17'h0);
    checks++;
    if (dm_out !== 12'h0B2) begin
      errors++;
      $display("FAIL plan_read1: got %h required 0b2", dm_out);
    end
    proc_op(1, 1'b1, 17'h1FFFF);
    checks++;
    if (dm_out !== 12'h0B2) begin
      errors++;
      $display("FAIL read_before_write: got %h required 0b2", dm_out);
    end
    proc_op(1, 1'b0, 17'h0);
    checks++;
    if (dm_out !== 12'hFFF) begin
      errors++;
      $display("FAIL write_truncate: got %h required fff", dm_out);
    end
    // A load_go during RUN must neither restart nor relatch the dump length.
    load_len = 13'd5;
    dump_len = 13'd0;
    load_go  = 1'b1;
    tick();
    load_go = 1'b0;
    checks++;
    if (run_active !== 1'b1 || host_wready !== 1'b0) begin
      errors++;
      $display("FAIL load_go_in_run: run=%b wready=%b required 1 0", run_active, host_wready);
    end
    run_ops(30, 8, 23);
    end_run(1'b1, 5, 17'($urandom()));
    dump_and_check(1, 2, 0, 0);
  endtask

  task automatic test_wrap();
    // Preload words presented while in DONE must not reach memory.
    host_wvalid = 1'b1;
    host_wdata  = 12'h5A5;
    tick();
    tick();
    host_wvalid = 1'b0;
    start_session(0, 12'hFFF, 2);
    proc_op(5, 1'b0, 17'h0);
    proc_op(2, 1'b0, 17'h0);
    proc_op(12'hFFF, 1'b1, 17'($urandom()));
    proc_op(0, 1'b1, 17'($urandom()));
    run_ops(20, 0, 31);
    end_run(1'b0, 0, 17'h0);
    dump_and_check(12'hFFF, 2, 0, 0);
  endtask

  task automatic test_stall();
    int n;
    n = $urandom_range(4, 8);
    start_session(n, 0, n);
    for (int i = 0; i < n; i++) exp_q.push_back(DATA_W'($urandom()));
    load_words();
    run_ops(10, 40, 60);
    end_run(1'b0, 0, 17'h0);
    dump_and_check(0, n, 1, 5);
  endtask

  task automatic test_reset_mid_load();
    start_session(6, 0, 6);
    host_wvalid = 1'b1;
    host_wdata  = 12'h123;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_load");
    host_wvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_all_zero("idle_after_reset");
    mem_m[0] = 12'h123;
    mem_m[1] = 12'h123;
  endtask

  task automatic test_zero_lengths();
    start_session(0, 0, 0);
    proc_op(0, 1'b0, 17'h0);
    end_run(1'b0, 0, 17'h0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (done !== 1'b1 || host_rvalid !== 1'b0) begin
        errors++;
        $display("FAIL zero_dump cycle %0d: done=%b rvalid=%b required 1 0", i, done, host_rvalid);
      end
      tick();
    end
  endtask

  task automatic test_random_sessions();
    int n;
    int base;
    int len;
    for (int r = 0; r < 3; r++) begin
      n    = $urandom_range(1, 12);
      base = $urandom_range(0, n - 1);
      len  = $urandom_range(1, n - base);
      start_session(n, base, len);
      for (int i = 0; i < n; i++) exp_q.push_back(DATA_W'($urandom()));
      load_words();
      run_ops(15, 0, 20);
      end_run(1'($urandom_range(0, 1)), $urandom_range(0, 20), 17'($urandom()));
      dump_and_check(base, len, $urandom_range(0, len - 1), $urandom_range(0, 4));
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    test_reset();
    test_load_run_dump();
    test_wrap();
    test_stall();
    test_reset_mid_load();
    test_zero_lengths();
    test_random_sessions();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_controller.md
Name: dm_controller

Overview:
- Data-memory subsystem on the processor's data side: consumes the processor's address register output, bus value and registered write strobe; returns the read data word.
- A host-side stream port preloads operand data before execution and drains a result region after the processor raises end_process.
- A sequencer FSM arbitrates memory ownership between host and processor and issues a one-cycle start pulse that releases the processor.

Parameters:
DATA_W, 12, data word width (matches dm_out width)
ADDR_W, 12, address width (matches ar_out width)
DEPTH, 4096, number of words; must equal 2**ADDR_W

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
proc_addr  in  ADDR_W  processor address (ar_out)
proc_wdata  in  17  processor bus value (bus_out); only bits [DATA_W-1:0] are stored
proc_we  in  1  processor write strobe (dm_en, already registered by the processor)
end_process  in  1  processor completion flag
dm_out  out  DATA_W  registered read data to processor
proc_start  out  1  one-cycle pulse on entry to RUN
run_active  out  1  high while in RUN
load_go  in  1  host command: start a load/run/dump session (sampled in IDLE or DONE only)
load_len  in  ADDR_W+1  number of words to preload from address 0, latched on load_go
dump_base  in  ADDR_W  first address of result region, latched on load_go
dump_len  in  ADDR_W+1  number of result words, latched on load_go
host_wvalid  in  1  preload word valid
host_wdata  in  DATA_W  preload word
host_wready  out  1  controller accepts preload word
host_rvalid  out  1  result word valid
host_rdata  out  DATA_W  result word
host_rready  in  1  host accepts result word
done  out  1  high in DONE

Behaviour:
- Reset (async, any state): state=IDLE; dm_out=0, proc_start=0, run_active=0, host_wready=0, host_rvalid=0, host_rdata=0, done=0; counters and latched lengths cleared. Memory contents are not cleared.
- States: IDLE, LOAD, RUN, DUMP, DONE.
- IDLE/DONE + load_go=1:
  - Latch load_len, dump_base, dump_len; cnt=0; clear done.
  - load_len=0: go to RUN directly.
  - Otherwise: go to LOAD.
- LOAD:
  - host_wready=1.
  - On host_wvalid&&host_wready: mem[cnt]<=host_wdata, cnt++.
  - Accepting word index load_len-1: host_wready drops next cycle, state goes to RUN.
  - proc_we ignored in LOAD.
- RUN:
  - proc_start=1 for the first RUN cycle only; run_active=1 throughout.
  - Each cycle: dm_out<=mem[proc_addr] (1-cycle latency). If proc_we=1: mem[proc_addr]<=proc_wdata[DATA_W-1:0].
  - Same-cycle read+write to the same address returns OLD data (read-before-write).
  - end_process=1 sampled: go to DUMP, or DONE if latched dump_len=0. A write on that same edge is still performed.
- Outside RUN: dm_out holds its last value, and proc_we is ignored.
- DUMP:
  - cnt=0 on entry. Read address=(dump_base+cnt) mod DEPTH (wraps at DEPTH-1 -> 0).
  - host_rvalid asserts one cycle after the read is issued.
  - host_rdata is stable while host_rvalid&&!host_rready.
  - On handshake: host_rvalid drops, cnt++, next read is issued. Maximum throughput is 1 word per 2 cycles.
  - After handshake of word dump_len-1: go to DONE.
- DONE: done=1, held until load_go or reset. load_go in DONE starts a new session; memory is not cleared.
- load_go outside IDLE/DONE: ignored.
- host_wvalid outside LOAD: ignored, no write.
- Reset mid-LOAD/RUN/DUMP: immediate return to IDLE; partially loaded or dumped data is discarded from the handshake view.

Test Plan:
- Reset then load_go with load_len=3 and words 0x0A1,0x0B2,0x0C3 (wvalid held) -> mem[0..2] written; LOAD lasts 3 handshake cycles; proc_start pulses once; run_active=1.
- RUN with proc_addr=1 -> dm_out=0x0B2 on the following edge. Then proc_we=1, proc_addr=1, proc_wdata=0x1_FFFF -> that cycle's dm_out=0x0B2; next read of address 1 gives 0xFFF.
- end_process with dump_base=1, dump_len=2, host_rready=1 -> host_rdata 0xFFF then 0x0C3; done=1 afterwards.
- dump_base=0xFFF, dump_len=2 -> reads addresses 0xFFF then 0x000 (wrap).
- host_rready held low for 5 cycles in DUMP -> host_rvalid stays 1 and host_rdata is unchanged; the word completes when rready rises.
- load_len=0 and dump_len=0 -> IDLE->RUN directly; end_process -> DONE with no rvalid. Also: assert rst_n=0 mid-LOAD -> all outputs zero asynchronously, state IDLE.
